count_avg: RTL
==============

# count_avg

Downstream consumer of the oscillator period counter. Takes the 9-bit period count and the counter's `reset` pulse, which marks a new count. Discards out-of-range and partial periods, averages a window of 2^LOG2N valid periods, and hands the rounded mean to the readout logic over a valid/ready handshake.

## Interface
- W, 9: width of the `count` input and the `avg` output
- LOG2N, 3: log2 of the window length, range 1..6; window = 2^LOG2N samples
- CNT_MIN, 4: smallest accepted count (inclusive)
- CNT_MAX, 500: largest accepted count (inclusive)

- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  enable; low forces IDLE and clears the window
- sample_in  in  1  period-counter `reset` strobe
- count  in  W  period-counter `count`
- avg  out  W  rounded window mean
- avg_valid  out  1  `avg` holds an unconsumed result
- avg_ready  in  1  consumer accepts `avg` when high together with `avg_valid`
- reject  out  1  one-cycle pulse when a captured sample is discarded
- overrun  out  1  sticky: a result was overwritten before it was accepted

## Operation
- Capture: s1 <= sample_in and s2 <= s1 each cycle. `count` is captured at the edge where s1 & ~s2, i.e. the second edge after sample_in is first registered high. Only one capture per sample_in high run, regardless of its length.
- States: IDLE, PRIME, ACC.
  - IDLE: entered on reset or when en = 0. Clears acc, n, s1, s2 and overrun. avg_valid = 0.
  - IDLE -> PRIME when en = 1.
  - PRIME: the first capture is discarded (partial period) without a reject pulse, then PRIME -> ACC.
  - ACC: a capture with CNT_MIN <= count <= CNT_MAX adds to acc (W+LOG2N bits) and increments n (LOG2N+1 bits). Otherwise reject pulses for 1 cycle and acc/n are unchanged.
- Window done: when n reaches 2^LOG2N, compute avg = min((acc + 2^(LOG2N-1)) >> LOG2N, 2^W-1). In the same edge, load avg, set avg_valid, and clear acc and n. The state stays ACC, so the next window runs back-to-back.
- Handshake:
  - avg_valid clears on the edge where avg_valid & avg_ready.
  - avg is stable while avg_valid = 1 unless an overwrite occurs.
  - Overwrite: if a window completes while avg_valid = 1 and avg_ready = 0, the new result replaces avg, avg_valid stays 1, and overrun sets.
  - If a window completes in the same cycle as avg_valid & avg_ready, the new result loads, avg_valid stays 1, and overrun does not set.
- overrun is cleared only by IDLE.
- en falling mid-window: the partial window is lost and avg_valid drops at the next edge.
- Reset values: avg = 0, avg_valid = 0, reject = 0, overrun = 0; state IDLE.

## Timing
- sample_in rise to capture: 2 edges.
- Capture to acc update: same edge.
- Last sample of the window to avg_valid high: 1 edge after capture. avg_valid is a registered output.
- reject is asserted in the cycle following the capturing edge.
- avg_ready is sampled combinationally only in the valid & ready term. There is no combinational path from any input to any output.
- Minimum sample_in period supported: 3 cycles.

## Configuration
- COUNT_AVG_MINMAX_EN defined: adds outputs win_min [W] and win_max [W].
  - They hold the smallest and largest accepted count of the window that produced avg.
  - They load alongside avg and share the avg_valid qualifier.
  - Running min resets to 2^W-1 and running max to 0 at each window start. Both outputs reset to 0.
- Not defined: no ports and no min/max logic.

## Structure
- Package count_avg_pkg holds:
  - state enum (IDLE, PRIME, ACC);
  - default W, LOG2N, CNT_MIN, CNT_MAX constants;
  - a function returning the rounded, saturated mean.
- Sub-module count_capture: the s1/s2 edge detector plus count register. It outputs cap_stb (1 cycle) and cap_val [W] into the window FSM.

## Test plan
- en = 1, LOG2N = 3, nine strobes of count 100 with avg_ready = 1 -> first discarded; after the ninth, avg = 100 and avg_valid pulses 1 cycle.
- Window counts 100,101,101,101,101,101,101,101 (sum 807) -> avg = 101 (807+4 = 811, >>3 = 101). Counts 3 and 501 inside a window -> reject pulses twice, window still needs 8 accepted samples.
- sample_in held high 5 cycles -> exactly one capture.
- avg_ready = 0 across two completed windows -> overrun = 1, avg equals the second window mean; drop en -> overrun = 0 and avg_valid = 0 next edge.
- reset_n asserted mid-window, asynchronous to clk -> all outputs 0 immediately; after release, the first capture is treated as PRIME.
- With COUNT_AVG_MINMAX_EN, window 90..97 -> win_min = 90, win_max = 97, avg = 94.

Source files
------------

// File: rtl/count_avg_pkg.sv
// count_avg_pkg
// Shared definitions for the period-count averager:
//   - state_t: window FSM states (IDLE, PRIME, ACC)
//   - DEF_* : default width, window size and accepted count range
//   - rounded_mean(): rounded, saturated mean of a 2^log2n sample sum
package count_avg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    ACC   = 2'd2
  } state_t;

  localparam int DEF_W       = 9;
  localparam int DEF_LOG2N   = 3;
  localparam int DEF_CNT_MIN = 4;
  localparam int DEF_CNT_MAX = 500;

  // Adds half an LSB of the divided result before shifting, so the mean
  // rounds to nearest, then clamps to the largest value w bits can hold.
  function automatic logic [31:0] rounded_mean(input logic [31:0] sum,
                                               input int          log2n,
                                               input int          w);
    logic [31:0] r;
    logic [31:0] max_v;
    max_v = (32'd1 << w) - 32'd1;
    r     = (sum + (32'd1 << (log2n - 1))) >> log2n;
    if (r > max_v) begin
      r = max_v;
    end
    return r;
  endfunction

endpackage

// File: rtl/count_capture.sv
// count_capture
// Edge detector on the period counter's reset strobe. A strobe is seen as
// one capture per high run of sample_in, regardless of how long it stays
// high; the count presented alongside the strobe is the one to use.
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   clear          synchronous clear of the detector (window FSM idle)
//   sample_in      period-counter reset strobe
//   count          period-counter count
//   cap_stb        one-cycle capture strobe (s1 & ~s2)
//   cap_val        count to capture on the edge where cap_stb is high
module count_capture
  import count_avg_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         sample_in,
  input  logic [W-1:0] count,
  output logic         cap_stb,
  output logic [W-1:0] cap_val
);

  logic s1;
  logic s2;

  // Two-stage delay of the strobe; s1 & ~s2 marks the first registered
  // high cycle of each run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else if (clear) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sample_in;
      s2 <= s1;
    end
  end

  // The window FSM registers cap_val on the capture edge itself, so the
  // count is handed over directly rather than through another flop.
  assign cap_stb = s1 & ~s2;
  assign cap_val = count;

endmodule

// File: rtl/count_avg.sv
// count_avg
// Averages windows of 2^LOG2N valid oscillator periods and offers the
// rounded mean over a valid/ready handshake. The first capture after
// enabling is a partial period and is dropped; captures outside
// CNT_MIN..CNT_MAX are rejected with a one-cycle pulse.
// Optional feature macro: COUNT_AVG_MINMAX_EN adds win_min / win_max.
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   en             enable; low returns to IDLE and drops the window
//   sample_in      period-counter reset strobe
//   count          period-counter count
//   avg            rounded window mean
//   avg_valid      avg holds an unconsumed result
//   avg_ready      consumer accepts avg when high with avg_valid
//   reject         one-cycle pulse per discarded out-of-range capture
//   overrun        sticky: a result was replaced before it was accepted
//   win_min        (macro only) smallest accepted count of the window
//   win_max        (macro only) largest accepted count of the window
module count_avg
  import count_avg_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int LOG2N   = DEF_LOG2N,
  parameter int CNT_MIN = DEF_CNT_MIN,
  parameter int CNT_MAX = DEF_CNT_MAX
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         sample_in,
  input  logic [W-1:0] count,
  output logic [W-1:0] avg,
  output logic         avg_valid,
  input  logic         avg_ready,
  output logic         reject,
  output logic         overrun
`ifdef COUNT_AVG_MINMAX_EN
  ,
  output logic [W-1:0] win_min,
  output logic [W-1:0] win_max
`endif
);

  localparam int             ACC_W  = W + LOG2N;
  localparam logic [LOG2N:0] N_FULL = {1'b1, {LOG2N{1'b0}}};
  localparam logic [W-1:0]   MIN_V  = W'(CNT_MIN);
  localparam logic [W-1:0]   MAX_V  = W'(CNT_MAX);

  state_t           state;
  state_t           next_state;
  logic             clear;
  logic             cap_stb;
  logic [W-1:0]     cap_val;
  logic             in_range;
  logic             accept;
  logic             window_done;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [LOG2N:0]   n;
  logic [LOG2N:0]   n_next;
  logic [W-1:0]     avg_next;

  // IDLE (or en low) holds the capture detector and window in reset, so a
  // strobe already in flight cannot leak into the next enabled period.
  assign clear = !en || (state == IDLE);

  count_capture #(
    .W (W)
  ) u_capture (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .sample_in (sample_in),
    .count     (count),
    .cap_stb   (cap_stb),
    .cap_val   (cap_val)
  );

  assign in_range    = (cap_val >= MIN_V) && (cap_val <= MAX_V);
  assign accept      = (state == ACC) && cap_stb && in_range;
  assign window_done = (n == N_FULL);
  assign avg_next    = W'(rounded_mean(32'(acc), LOG2N, W));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // PRIME waits for one capture to throw away; ACC then runs windows
  // back-to-back until en drops.
  always_comb begin
    next_state = state;
    if (!en) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = PRIME;
        PRIME:   if (cap_stb) next_state = ACC;
        ACC:     next_state = ACC;
        default: next_state = IDLE;
      endcase
    end
  end

  // A completed window restarts from zero; an accepted capture landing on
  // the same edge becomes the first sample of the new window.
  always_comb begin
    acc_next = window_done ? '0 : acc;
    n_next   = window_done ? '0 : n;
    if (accept) begin
      acc_next = acc_next + ACC_W'(cap_val);
      n_next   = n_next + (LOG2N + 1)'(1);
    end
  end

  // Accumulator, result register and handshake. Loading a new result
  // takes priority over the consumer's accept, so avg_valid stays high
  // when both happen together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      n         <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
      reject    <= 1'b0;
      overrun   <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      n         <= '0;
      avg_valid <= 1'b0;
      reject    <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      acc    <= acc_next;
      n      <= n_next;
      reject <= (state == ACC) && cap_stb && !in_range;
      if (window_done) begin
        avg       <= avg_next;
        avg_valid <= 1'b1;
        if (avg_valid && !avg_ready) begin
          overrun <= 1'b1;
        end
      end else if (avg_valid && avg_ready) begin
        avg_valid <= 1'b0;
      end
    end
  end

`ifdef COUNT_AVG_MINMAX_EN
  logic [W-1:0] run_min;
  logic [W-1:0] run_max;
  logic [W-1:0] run_min_next;
  logic [W-1:0] run_max_next;

  // Running extremes restart at the opposite limits with each window so
  // the first accepted count always replaces them.
  always_comb begin
    run_min_next = window_done ? '1 : run_min;
    run_max_next = window_done ? '0 : run_max;
    if (accept) begin
      if (cap_val < run_min_next) run_min_next = cap_val;
      if (cap_val > run_max_next) run_max_next = cap_val;
    end
  end

  // Published extremes load on the same edge as avg.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_min <= '1;
      run_max <= '0;
      win_min <= '0;
      win_max <= '0;
    end else if (clear) begin
      run_min <= '1;
      run_max <= '0;
    end else begin
      run_min <= run_min_next;
      run_max <= run_max_next;
      if (window_done) begin
        win_min <= run_min;
        win_max <= run_max;
      end
    end
  end
`endif

endmodule
